// File: rtl/load_store_unit.sv
// Load/store unit between execute and a single-byte data memory.
// Halfwords are split into two little-endian byte accesses.
module load_store_unit #(
    parameter int ADDR_W   = 8,
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_wide,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        LATCH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              write_q;
    logic              wide_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;

    logic              accept;
    logic              done;
    logic              capture_lo;
    logic              load_done;
    logic [ADDR_W-1:0] addr_hi;
    logic [7:0]        ext;

    assign accept  = req_valid && req_ready;
    assign addr_hi = addr_q + ADDR_W'(1);
    assign ext     = SIGN_EXT ? {8{mem_rdata[7]}} : 8'h00;

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and memory strobes; bus idle unless accessing.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        done       = 1'b0;
        capture_lo = 1'b0;
        load_done  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    state_nxt = ACC_LO;
                end
            end
            ACC_LO: begin
                mem_addr = addr_q;
                if (write_q) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q[7:0];
                end else begin
                    mem_read = 1'b1;
                end
                if (wide_q) begin
                    state_nxt = ACC_HI;
                end else if (write_q) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else begin
                    state_nxt = LATCH;
                end
            end
            ACC_HI: begin
                mem_addr = addr_hi;
                if (write_q) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q[15:8];
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else begin
                    mem_read   = 1'b1;
                    capture_lo = 1'b1;
                    state_nxt  = LATCH;
                end
            end
            LATCH: begin
                done      = 1'b1;
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request fields on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
        end else if (accept) begin
            write_q <= req_write;
            wide_q  <= req_wide;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Low byte of a halfword load arrives while the high byte is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= 8'h00;
        end else if (capture_lo) begin
            lo_q <= mem_rdata;
        end
    end

    // Completion pulse and load result; stores leave resp_data alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= 16'h0000;
        end else begin
            resp_valid <= done;
            if (load_done) begin
                if (wide_q) begin
                    resp_data <= {mem_rdata, lo_q};
                end else begin
                    resp_data <= {ext, mem_rdata};
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: zero- and sign-extending instances
// share stimulus; results checked against a byte-array model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_wide = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;

    logic        req_ready0, req_ready1;
    logic        resp_valid0, resp_valid1;
    logic [15:0] resp_data0, resp_data1;
    logic [7:0]  mem_addr0, mem_addr1;
    logic [7:0]  mem_wdata0, mem_wdata1;
    logic        mem_read0, mem_read1;
    logic        mem_write0, mem_write1;
    logic [7:0]  rdata0 = 8'h00;
    logic [7:0]  rdata1 = 8'h00;

    logic [7:0]  mem0 [256] = '{default: 8'h00};
    logic [7:0]  mem1 [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};

    logic [15:0] last0 = 16'h0000;
    logic [15:0] last1 = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .SIGN_EXT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready0),
        .req_write(req_write), .req_wide(req_wide),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_data(resp_data0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_rdata(rdata0)
    );

    load_store_unit #(.ADDR_W(8), .SIGN_EXT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready1),
        .req_write(req_write), .req_wide(req_wide),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_data(resp_data1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_rdata(rdata1)
    );

    // Byte-wide memories with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write0) mem0[mem_addr0] <= mem_wdata0;
        if (mem_read0) rdata0 <= mem0[mem_addr0];
        if (mem_write1) mem1[mem_addr1] <= mem_wdata1;
        if (mem_read1) rdata1 <= mem1[mem_addr1];
    end

    // Cycles from acceptance to completion: one per byte moved,
    // one for acceptance, one more for a load to return data.
    function automatic int exp_lat(input logic w, input logic wide);
        return 1 + (wide ? 2 : 1) + (w ? 0 : 1);
    endfunction

    function automatic logic [15:0] exp_load(input logic [7:0] a,
                                             input logic wide,
                                             input logic se);
        logic [7:0] a1;
        logic [7:0] b;
        a1 = a + 8'd1;
        b = ref_mem[a];
        if (wide) return {ref_mem[a1], b};
        if (se && b >= 8'h80) return 16'hFF00 + {8'h00, b};
        return {8'h00, b};
    endfunction

    function automatic void model_store(input logic [7:0] a,
                                        input logic wide,
                                        input logic [15:0] d);
        logic [7:0] a1;
        a1 = a + 8'd1;
        ref_mem[a] = d[7:0];
        if (wide) ref_mem[a1] = d[15:8];
    endfunction

    // Issue one request and report latency, result and bus violations.
    task automatic do_req(input logic w, input logic wide,
                          input logic [7:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] r0,
                          output logic [15:0] r1, output int viol);
        int guard;
        @(negedge clk);
        req_write = w;
        req_wide  = wide;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_wide  = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 16'($urandom);
        lat = 1;
        viol = 0;
        while (!resp_valid0 && lat < 12) begin
            if (req_ready0) viol++;
            if (mem_read0 && mem_write0) viol++;
            if (resp_valid1 !== resp_valid0) viol++;
            @(negedge clk);
            lat++;
        end
        if (resp_valid1 !== resp_valid0) viol++;
        r0 = resp_data0;
        r1 = resp_data1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({req_ready0, resp_valid0, resp_data0, mem_read0, mem_write0,
             mem_addr0, mem_wdata0} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h rd=%b wr=%b a=%h wd=%h want all 0",
                     req_ready0, resp_valid0, resp_data0, mem_read0,
                     mem_write0, mem_addr0, mem_wdata0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready0 !== 1'b1 || req_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b/%b want 1", req_ready0, req_ready1);
        end
    endtask

    task automatic test_byte_store_load;
        int lat, viol;
        logic [15:0] r0, r1;
        do_req(1'b1, 1'b0, 8'h10, 16'h77A5, lat, r0, r1, viol);
        model_store(8'h10, 1'b0, 16'h77A5);
        n_cmp++;
        if (lat !== 2 || viol !== 0 || r0 !== last0) begin
            n_err++;
            $display("FAIL byte_store: got lat=%0d viol=%0d rd=%h want lat=2 viol=0 rd=%h",
                     lat, viol, r0, last0);
        end
        n_cmp++;
        if (mem0[8'h10] !== 8'hA5) begin
            n_err++;
            $display("FAIL byte_store_mem: got %h want a5", mem0[8'h10]);
        end
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, lat, r0, r1, viol);
        n_cmp++;
        if (lat !== 3 || viol !== 0 || r0 !== 16'h00A5 || r1 !== exp_load(8'h10, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL byte_load: got lat=%0d viol=%0d r0=%h r1=%h want lat=3 r0=00a5 r1=%h",
                     lat, viol, r0, r1, exp_load(8'h10, 1'b0, 1'b1));
        end
        last0 = exp_load(8'h10, 1'b0, 1'b0);
        last1 = exp_load(8'h10, 1'b0, 1'b1);
    endtask

    task automatic test_halfword;
        int lat, viol;
        logic [15:0] r0, r1;
        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, lat, r0, r1, viol);
        model_store(8'h20, 1'b1, 16'hBEEF);
        n_cmp++;
        if (lat !== 3 || viol !== 0 || r1 !== last1) begin
            n_err++;
            $display("FAIL half_store: got lat=%0d viol=%0d rd=%h want lat=3 rd=%h",
                     lat, viol, r1, last1);
        end
        n_cmp++;
        if (mem0[8'h20] !== 8'hEF || mem0[8'h21] !== 8'hBE) begin
            n_err++;
            $display("FAIL half_store_mem: got %h %h want ef be", mem0[8'h20], mem0[8'h21]);
        end
        do_req(1'b0, 1'b1, 8'h20, 16'h0000, lat, r0, r1, viol);
        n_cmp++;
        if (lat !== 4 || viol !== 0 || r0 !== 16'hBEEF || r1 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL half_load: got lat=%0d viol=%0d r0=%h r1=%h want lat=4 beef",
                     lat, viol, r0, r1);
        end
        last0 = 16'hBEEF;
        last1 = 16'hBEEF;
    endtask

    task automatic test_wrap;
        int lat, viol;
        logic [15:0] r0, r1;
        do_req(1'b1, 1'b1, 8'hFF, 16'h1234, lat, r0, r1, viol);
        model_store(8'hFF, 1'b1, 16'h1234);
        n_cmp++;
        if (mem0[8'hFF] !== 8'h34 || mem0[8'h00] !== 8'h12 || lat !== 3) begin
            n_err++;
            $display("FAIL wrap_store: got ff=%h 00=%h lat=%0d want 34 12 lat=3",
                     mem0[8'hFF], mem0[8'h00], lat);
        end
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000, lat, r0, r1, viol);
        n_cmp++;
        if (r0 !== 16'h1234 || lat !== 4 || viol !== 0) begin
            n_err++;
            $display("FAIL wrap_load: got %h lat=%0d viol=%0d want 1234 lat=4", r0, lat, viol);
        end
        last0 = 16'h1234;
        last1 = 16'h1234;
    endtask

    task automatic test_sign_ext;
        int lat, viol;
        logic [15:0] r0, r1;
        do_req(1'b1, 1'b0, 8'h30, 16'h0080, lat, r0, r1, viol);
        model_store(8'h30, 1'b0, 16'h0080);
        do_req(1'b0, 1'b0, 8'h30, 16'h0000, lat, r0, r1, viol);
        n_cmp++;
        if (r1 !== 16'hFF80 || r0 !== 16'h0080) begin
            n_err++;
            $display("FAIL sext_neg: got se=%h ze=%h want ff80 0080", r1, r0);
        end
        do_req(1'b1, 1'b0, 8'h30, 16'hFF7F, lat, r0, r1, viol);
        model_store(8'h30, 1'b0, 16'hFF7F);
        n_cmp++;
        if (r1 !== 16'hFF80 || r0 !== 16'h0080) begin
            n_err++;
            $display("FAIL store_keeps_resp: got se=%h ze=%h want ff80 0080", r1, r0);
        end
        do_req(1'b0, 1'b0, 8'h30, 16'h0000, lat, r0, r1, viol);
        n_cmp++;
        if (r1 !== 16'h007F || r0 !== 16'h007F) begin
            n_err++;
            $display("FAIL sext_pos: got se=%h ze=%h want 007f 007f", r1, r0);
        end
        last0 = 16'h007F;
        last1 = 16'h007F;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  addrs [3];
        int          acc_c [3];
        int          rsp_c [3];
        logic [15:0] rd [3];
        int          na, nr;
        bit          took;
        addrs[0] = 8'h10;
        addrs[1] = 8'h20;
        addrs[2] = 8'h30;
        na = 0;
        nr = 0;
        @(negedge clk);
        req_write = 1'b0;
        req_wide  = 1'b0;
        req_addr  = addrs[0];
        req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            took = 1'b0;
            if (resp_valid0 && nr < 3) begin
                rsp_c[nr] = c;
                rd[nr] = resp_data0;
                nr++;
            end
            if (req_ready0 && req_valid && na < 3) begin
                acc_c[na] = c;
                na++;
                took = 1'b1;
            end
            @(negedge clk);
            if (took) begin
                if (na < 3) req_addr = addrs[na];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (na !== 3 || nr !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got acc=%0d resp=%0d want 3 3", na, nr);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (rsp_c[k] - acc_c[k] !== 3 || rd[k] !== exp_load(addrs[k], 1'b0, 1'b0)) begin
                    n_err++;
                    $display("FAIL b2b_load%0d: got lat=%0d data=%h want lat=3 data=%h",
                             k, rsp_c[k] - acc_c[k], rd[k], exp_load(addrs[k], 1'b0, 1'b0));
                end
                if (k > 0) begin
                    n_cmp++;
                    if (acc_c[k] !== rsp_c[k-1]) begin
                        n_err++;
                        $display("FAIL b2b_accept%0d: got cycle %0d want %0d",
                                 k, acc_c[k], rsp_c[k-1]);
                    end
                end
            end
        end
        last0 = exp_load(addrs[2], 1'b0, 1'b0);
        last1 = exp_load(addrs[2], 1'b0, 1'b1);
    endtask

    task automatic test_random;
        int lat, viol;
        logic [15:0] r0, r1, d, e0, e1;
        logic [7:0] a;
        logic w, wide;
        for (int i = 0; i < 60; i++) begin
            w    = 1'($urandom);
            wide = 1'($urandom);
            a    = {($urandom % 2 == 0) ? 4'hF : 4'h5, 4'($urandom)};
            d    = 16'($urandom);
            do_req(w, wide, a, d, lat, r0, r1, viol);
            n_cmp++;
            if (lat !== exp_lat(w, wide) || viol !== 0) begin
                n_err++;
                $display("FAIL rand%0d_timing: got lat=%0d viol=%0d want lat=%0d viol=0",
                         i, lat, viol, exp_lat(w, wide));
            end
            if (w) begin
                e0 = last0;
                e1 = last1;
                model_store(a, wide, d);
            end else begin
                e0 = exp_load(a, wide, 1'b0);
                e1 = exp_load(a, wide, 1'b1);
                last0 = e0;
                last1 = e1;
            end
            n_cmp++;
            if (r0 !== e0 || r1 !== e1) begin
                n_err++;
                $display("FAIL rand%0d_data w=%b wide=%b a=%h: got %h/%h want %h/%h",
                         i, w, wide, a, r0, r1, e0, e1);
            end
        end
    endtask

    task automatic test_reset_mid;
        int guard;
        int seen;
        @(negedge clk);
        req_write = 1'b1;
        req_wide  = 1'b1;
        req_addr  = 8'h40;
        req_wdata = 16'h5A5A;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (mem_write0 !== 1'b1 || mem_addr0 !== 8'h40) begin
            n_err++;
            $display("FAIL mid_pre: got wr=%b a=%h want 1 40", mem_write0, mem_addr0);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_write0 !== 1'b0 || req_ready0 !== 1'b0 || mem_addr0 !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: got wr=%b rdy=%b a=%h want 0 0 00",
                     mem_write0, req_ready0, mem_addr0);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid0 || resp_valid1) seen++;
        end
        rst_n = 1'b1;
        last0 = 16'h0000;
        last1 = 16'h0000;
        @(negedge clk);
        n_cmp++;
        if (req_ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_ready: got %b want 1", req_ready0);
        end
        repeat (4) begin
            if (resp_valid0 || resp_valid1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0 || resp_data0 !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_noresp: got pulses=%0d rd=%h want 0 0000", seen, resp_data0);
        end
        n_cmp++;
        if (mem0[8'h40] !== ref_mem[8'h40] || mem0[8'h41] !== ref_mem[8'h41]) begin
            n_err++;
            $display("FAIL mid_mem: got %h %h want %h %h",
                     mem0[8'h40], mem0[8'h41], ref_mem[8'h40], ref_mem[8'h41]);
        end
    endtask

    initial begin
        test_reset();
        test_byte_store_load();
        test_halfword();
        test_wrap();
        test_sign_ext();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and data_memory.
- Accepts one byte or 16-bit halfword load/store request at a time over a valid/ready handshake.
- Drives data_memory's single-byte, one-cycle-read-latency port. A halfword becomes two sequential byte accesses, little-endian.
- Returns load data and a completion pulse to writeback.

Parameters:
- ADDR_W, 8, width of byte address; addresses wrap modulo 2^ADDR_W.
- SIGN_EXT, 0, when 1 byte loads sign-extend into resp_data[15:8]; when 0 they zero-extend.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_wide  in  1  1 = halfword (2 bytes), 0 = byte
- req_addr  in  ADDR_W  byte address (low byte for halfword)
- req_wdata  in  16  store data; [7:0] only for byte stores
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_data  out  16  load result, valid while resp_valid=1
- mem_addr  out  ADDR_W  to data_memory addr
- mem_wdata  out  8  to data_memory write_data
- mem_read  out  1  to data_memory mem_read
- mem_write  out  1  to data_memory mem_write
- mem_rdata  in  8  from data_memory read_data; holds the byte read at the previous edge

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE immediately.
  - req_ready=0 while rst_n=0, then 1 in IDLE.
  - resp_valid=0, resp_data=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 combinationally.
- Reset mid-operation: the in-flight access is abandoned and no response is produced. A halfword store interrupted after its low byte leaves the low byte written and the high byte unwritten; this is accepted.
- Handshake:
  - req_ready=1 only in IDLE.
  - Acceptance is req_valid && req_ready at a rising edge. req_write, req_wide, req_addr and req_wdata are latched into internal registers.
  - Inputs are ignored when not accepted.
- States: IDLE, ACC_LO, ACC_HI, LATCH.
  - IDLE: on acceptance go to ACC_LO; else stay.
  - ACC_LO: mem_addr=A. Load: mem_read=1. Store: mem_write=1, mem_wdata=wdata[7:0]. Next state:
    - halfword -> ACC_HI
    - byte load -> LATCH
    - byte store -> IDLE, with resp_valid set for one cycle
  - ACC_HI: mem_addr=(A+1) mod 2^ADDR_W. Load: mem_read=1 and capture mem_rdata into lo_reg. Store: mem_write=1, mem_wdata=wdata[15:8]. Next state: load -> LATCH; store -> IDLE with resp_valid pulse.
  - LATCH: no memory strobe.
    - Halfword: resp_data <= {mem_rdata, lo_reg}.
    - Byte: resp_data <= {ext, mem_rdata}, where ext = 8'h00, or 8{mem_rdata[7]} if SIGN_EXT=1.
    - Set resp_valid pulse, go to IDLE.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and LATCH.
- resp_valid and resp_data are registered. resp_valid is high for exactly one cycle, the first IDLE cycle after completion. resp_data holds its value until the next load completes; stores do not change resp_data.
- Latency from accepting edge to resp_valid cycle:
  - byte store 2
  - halfword store 3
  - byte load 3
  - halfword load 4
- A new request may be accepted in the same cycle resp_valid is high, giving back-to-back throughput.
- Address wrap: halfword at A = 2^ADDR_W-1 accesses the high byte at address 0.
- No memory access is issued speculatively; the bus is idle in IDLE.

Test Plan:
- Reset mid-access: assert rst_n=0 during ACC_LO of a store.
  - -> mem_write drops in the same cycle.
  - -> req_ready=0 during reset, 1 after.
  - -> no resp_valid.
- Byte store then load, SIGN_EXT=0: store 8'hA5 to 8'h10, then load 8'h10.
  - -> store resp_valid 2 cycles after acceptance.
  - -> load resp_data=16'h00A5, 3 cycles after acceptance.
- Halfword round trip: store 16'hBEEF at 8'h20.
  - -> mem[8'h20]=8'hEF, mem[8'h21]=8'hBE.
  - -> halfword load returns 16'hBEEF at latency 4.
- Wrap-around: halfword store 16'h1234 at 8'hFF.
  - -> mem[8'hFF]=8'h34, mem[8'h00]=8'h12.
  - -> halfword load from 8'hFF returns 16'h1234.
- SIGN_EXT=1: byte at 8'h30=8'h80 -> byte load returns 16'hFF80. Byte 8'h7F -> 16'h007F.
- Back-to-back and stall:
  - Hold req_valid high with 3 consecutive byte loads -> each accepted in its predecessor's resp_valid cycle, with req_ready=0 in between.
  - Requests presented while busy are not lost once req_ready=1.
